// File: rtl/cpu_ctrl.sv
// Instruction register and multi-cycle sequencer for a small load/store datapath.
// Control outputs are registered Moore outputs, computed from the next state.
module cpu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_RD, S_WRITE_IMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic       w_q, w_d;
  logic [2:0] readnum_q, readnum_d;
  logic [2:0] writenum_q, writenum_d;
  logic       write_q, write_d;
  logic [1:0] vsel_q, vsel_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       asel_q, asel_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic [1:0] shift_q, shift_d;
  logic [1:0] aluop_q, aluop_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  // IR only changes in WAIT, so outputs for every later state can use ir_q.
  always_comb begin
    ir_d    = ir_q;
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)      state_d = S_WRITE_IMM;
        else if (is_mov_reg) state_d = S_GET_B;
        else if (is_alu)     state_d = S_GET_A;
        else                 state_d = S_WAIT;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_RD;
      S_WRITE_RD:  state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase

    w_d        = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    write_d    = 1'b0;
    vsel_d     = 2'b00;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    asel_d     = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    case (state_d)
      S_WAIT:  w_d = 1'b1;
      S_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        shift_d = sh;
        asel_d  = is_mov_reg;
        aluop_d = is_alu ? op : 2'b00;
        loads_d = is_cmp;
        loadc_d = !is_cmp;
      end
      S_WRITE_RD: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum_d = rn;
        vsel_d     = 2'b10;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT;
      ir_q       <= 16'h0000;
      w_q        <= 1'b1;
      readnum_q  <= 3'd0;
      writenum_q <= 3'd0;
      write_q    <= 1'b0;
      vsel_q     <= 2'b00;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      asel_q     <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      shift_q    <= 2'b00;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= w_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      vsel_q     <= vsel_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      asel_q     <= asel_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
    end
  end

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign vsel     = vsel_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign shift    = shift_q;
  assign ALUop    = aluop_q;

endmodule
